rr_mux_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one 2:1 data mux, and the downstream sink behind it, between requester 0 and requester 1. It drives the mux select, returns per-requester grants and presents the selected data with a valid/ready handshake. A per-grant burst limit guarantees fairness. It sits between two producers and a single-consumer datapath.

---
 rtl/rr_mux_arbiter_pkg.sv | 13 +
 rtl/rr_mux_arbiter_if.sv | 28 ++
 rtl/rr_mux_arbiter_mux2.sv | 13 +
 rtl/rr_mux_arbiter.sv | 82 ++++++++
 tb/tb_rr_mux_arbiter.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared state encoding and sizing helper for the two-requester round-robin arbiter.
// One-hot-style grant states let gnt0/gnt1/sel come straight off the state flops.
package rr_mux_arb_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  function automatic int cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/sink bundle for rr_mux_arbiter: two request+data inputs, one valid/ready output.
// slave = arbiter side, master = the producers/sink driving it.
interface rr_mux_arbiter_if #(
  parameter int DW = 8
);

  logic          req0;
  logic          req1;
  logic [DW-1:0] d0;
  logic [DW-1:0] d1;
  logic          out_ready;
  logic          gnt0;
  logic          gnt1;
  logic          sel;
  logic [DW-1:0] y;
  logic          out_valid;

  modport slave (
    input  req0, req1, d0, d1, out_ready,
    output gnt0, gnt1, sel, y, out_valid
  );

  modport master (
    output req0, req1, d0, d1, out_ready,
    input  gnt0, gnt1, sel, y, out_valid
  );

endinterface

// File: rtl/rr_mux_arbiter_mux2.sv
// Plain 2:1 data mux, zero latency: y = s ? b : a.
module mux2_dw #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          s,
  output logic [DW-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 mux; grant lands one cycle after request.
// out_ready low stalls the burst counter and holds the grant; bursts capped at MAX_BURST beats.
module rr_mux_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  rr_mux_arbiter_if.slave bus
);

  localparam int            CW       = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic          sel_w;
  logic          beat;
  logic          own_req;
  logic          oth_req;
  logic          grant_end;

  assign sel_w         = state_q[1];
  assign bus.gnt0      = state_q[0];
  assign bus.gnt1      = state_q[1];
  assign bus.sel       = sel_w;
  assign bus.out_valid = (state_q[0] & bus.req0) | (state_q[1] & bus.req1);

  assign beat      = bus.out_valid & bus.out_ready;
  assign own_req   = state_q[1] ? bus.req1 : bus.req0;
  assign oth_req   = state_q[1] ? bus.req0 : bus.req1;
  assign grant_end = !own_req || (beat && (cnt_q == CNT_LAST));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req0 && (!bus.req1 || !ptr_q)) state_d = G0;
        else if (bus.req1)                     state_d = G1;
      end
      G0, G1: begin
        if (grant_end) begin
          // Priority moves to the other requester whenever a grant closes, even if it re-grants to us.
          cnt_d = '0;
          ptr_d = state_q[0];
          if (oth_req)      state_d = state_q[1] ? G0 : G1;
          else if (own_req) state_d = state_q;
          else              state_d = IDLE;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  mux2_dw #(.DW(DW)) u_mux (
    .a (bus.d0),
    .b (bus.d1),
    .s (sel_w),
    .y (bus.y)
  );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a MAX_BURST=4 instance for the main scenarios and a MAX_BURST=1 instance for alternation.
module tb_rr_mux_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  rr_mux_arbiter_if #(.DW(8)) ba ();
  rr_mux_arbiter_if #(.DW(8)) bb ();

  rr_mux_arbiter #(.DW(8), .MAX_BURST(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ba)
  );

  rr_mux_arbiter #(.DW(8), .MAX_BURST(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one clock and sample 1 ns after the edge; grants must stay mutually exclusive.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("excl_a", {31'd0, ba.gnt0 & ba.gnt1}, 32'd0);
    chk("excl_b", {31'd0, bb.gnt0 & bb.gnt1}, 32'd0);
  endtask

  logic [11:0] fair_pat;
  logic [5:0]  alt_pat;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    fair_pat = 12'b0000_1111_0000;
    alt_pat  = 6'b101010;
    rst = 1'b1;
    ba.req0 = 1'b0; ba.req1 = 1'b0; ba.d0 = 8'h3C; ba.d1 = 8'hA5; ba.out_ready = 1'b1;
    bb.req0 = 1'b0; bb.req1 = 1'b0; bb.d0 = 8'h11; bb.d1 = 8'h22; bb.out_ready = 1'b1;

    tick();
    tick();
    chk("rst_gnt0", {31'd0, ba.gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, ba.gnt1}, 32'd0);
    chk("rst_sel",  {31'd0, ba.sel},  32'd0);
    chk("rst_vld",  {31'd0, ba.out_valid}, 32'd0);
    chk("rst_y",    {24'd0, ba.y}, 32'h3C);
    rst = 1'b0;

    // Single requester 1: grant after one cycle, re-issued every 4 beats without a gap.
    ba.req1 = 1'b1;
    #1;
    chk("single_pre_gnt1", {31'd0, ba.gnt1}, 32'd0);
    chk("single_pre_vld",  {31'd0, ba.out_valid}, 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("single_gnt1", {31'd0, ba.gnt1}, 32'd1);
      chk("single_sel",  {31'd0, ba.sel}, 32'd1);
      chk("single_y",    {24'd0, ba.y}, 32'hA5);
      chk("single_vld",  {31'd0, ba.out_valid}, 32'd1);
      chk("single_cnt",  {30'd0, u_dut_a.cnt_q}, i % 4);
      tick();
    end
    ba.req1 = 1'b0;
    #1;
    chk("drop_vld", {31'd0, ba.out_valid}, 32'd0);
    tick();
    chk("drop_idle_gnt1", {31'd0, ba.gnt1}, 32'd0);
    chk("drop_idle_vld",  {31'd0, ba.out_valid}, 32'd0);

    // Fair sharing: G0 x4, G1 x4, G0 x4 with no idle cycle.
    ba.req0 = 1'b1;
    ba.req1 = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      chk("fair_sel",  {31'd0, ba.sel},  {31'd0, fair_pat[i]});
      chk("fair_gnt0", {31'd0, ba.gnt0}, {31'd0, ~fair_pat[i]});
      chk("fair_gnt1", {31'd0, ba.gnt1}, {31'd0, fair_pat[i]});
      chk("fair_vld",  {31'd0, ba.out_valid}, 32'd1);
      chk("fair_y",    {24'd0, ba.y}, fair_pat[i] ? 32'hA5 : 32'h3C);
      tick();
    end
    chk("fair_next_gnt1", {31'd0, ba.gnt1}, 32'd1);

    // Early release: two beats into G0, requester 0 drops.
    for (int i = 0; i < 4; i++) tick();
    chk("early_gnt0", {31'd0, ba.gnt0}, 32'd1);
    chk("early_cnt0", {30'd0, u_dut_a.cnt_q}, 32'd0);
    tick();
    tick();
    chk("early_cnt2", {30'd0, u_dut_a.cnt_q}, 32'd2);
    ba.req0 = 1'b0;
    #1;
    chk("early_vld",       {31'd0, ba.out_valid}, 32'd0);
    chk("early_gnt0_held", {31'd0, ba.gnt0}, 32'd1);
    tick();
    chk("early_gnt1", {31'd0, ba.gnt1}, 32'd1);
    chk("early_sel",  {31'd0, ba.sel}, 32'd1);
    chk("early_cnt",  {30'd0, u_dut_a.cnt_q}, 32'd0);

    // Backpressure in G1: grant and counter hold, then exactly 4 beats before hand-over.
    ba.out_ready = 1'b0;
    #1;
    chk("bp_vld", {31'd0, ba.out_valid}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_gnt1", {31'd0, ba.gnt1}, 32'd1);
      chk("bp_cnt",  {30'd0, u_dut_a.cnt_q}, 32'd0);
    end
    ba.out_ready = 1'b1;
    ba.req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_beat_gnt1", {31'd0, ba.gnt1}, 32'd1);
      chk("bp_beat_cnt",  {30'd0, u_dut_a.cnt_q}, i);
      tick();
    end
    chk("bp_hand_gnt0", {31'd0, ba.gnt0}, 32'd1);
    chk("bp_hand_gnt1", {31'd0, ba.gnt1}, 32'd0);
    chk("bp_hand_sel",  {31'd0, ba.sel}, 32'd0);

    // Asynchronous reset mid-burst with both requesting.
    tick();
    chk("mid_cnt", {30'd0, u_dut_a.cnt_q}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gnt0", {31'd0, ba.gnt0}, 32'd0);
    chk("arst_gnt1", {31'd0, ba.gnt1}, 32'd0);
    chk("arst_sel",  {31'd0, ba.sel}, 32'd0);
    chk("arst_vld",  {31'd0, ba.out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rel_gnt0", {31'd0, ba.gnt0}, 32'd0);
    tick();
    chk("rel_first_gnt0", {31'd0, ba.gnt0}, 32'd1);
    chk("rel_first_cnt",  {30'd0, u_dut_a.cnt_q}, 32'd0);

    // MAX_BURST = 1: select toggles every beat.
    bb.req0 = 1'b1;
    bb.req1 = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("mb1_sel", {31'd0, bb.sel}, {31'd0, alt_pat[i]});
      chk("mb1_y",   {24'd0, bb.y}, alt_pat[i] ? 32'h22 : 32'h11);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
